// File: rtl/matrix_operand_loader_pkg.sv
// Shared definitions for the matmul front-end and engine.
// Holds the loader FSM state encoding, header field offsets and the index width.
// Header layout: [7:0]=M, [15:8]=K, [23:16]=N, [31:24] ignored.
package matmul_pkg;

  // Index width, shared with the engine's element index math.
  localparam int IDX_W = 16;

  // Header field offsets and width.
  localparam int HDR_FIELD_W = 8;
  localparam int HDR_M_LSB   = 0;
  localparam int HDR_K_LSB   = 8;
  localparam int HDR_N_LSB   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4
  } state_t;

  // Extract one 8-bit dimension field from a header word.
  function automatic logic [HDR_FIELD_W-1:0] hdr_field(input logic [31:0] word, input int lsb);
    return word[lsb +: HDR_FIELD_W];
  endfunction

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Valid/ready word stream feeding the operand loader.
// Ports: s_valid, s_data (producer -> loader), s_ready (loader -> producer).
// A word transfers on a rising edge where s_valid && s_ready.
interface matrix_operand_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/matrix_operand_loader.sv
// Streaming loader: header, then A, then B (row-major) into operand arrays; pulses eng_start, waits eng_done.
// Latency: 1 + M*K + K*N accepted beats, then one START cycle; array/counter writes land at the accepting edge.
// Backpressure: s_ready is a pure state decode (high in IDLE/LOAD_A/LOAD_B), low from START until eng_done.
// Ports: clk, rst (async, active-high), s (stream slave), M_val/K_val/N_val, matrix_A, matrix_B,
//        eng_start, eng_done, busy, and err (sticky header error, only with LOADER_HDR_CHECK_EN).
// Optional feature macro: LOADER_HDR_CHECK_EN (header range checking and err port).
module matrix_operand_loader
  import matmul_pkg::*;
#(
  parameter int MAX_M = 100,
  parameter int MAX_K = 100,
  parameter int MAX_N = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix_operand_loader_if.slave s,
  output logic [7:0]            M_val,
  output logic [7:0]            K_val,
  output logic [7:0]            N_val,
  output logic [31:0]           matrix_A [MAX_M*MAX_K],
  output logic [31:0]           matrix_B [MAX_K*MAX_N],
  output logic                  eng_start,
  input  logic                  eng_done,
  output logic                  busy
`ifdef LOADER_HDR_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int A_DEPTH = MAX_M * MAX_K;
  localparam int B_DEPTH = MAX_K * MAX_N;
  localparam int A_AW    = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
  localparam int B_AW    = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;

  state_t state_q, state_d;

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] a_total_q, b_total_q;

  // Header decode straight off the stream word.
  logic [7:0]       hdr_m, hdr_k, hdr_n;
  logic [IDX_W-1:0] hdr_a_total, hdr_b_total;
  logic             hdr_ok;

  assign hdr_m       = hdr_field(s.s_data, HDR_M_LSB);
  assign hdr_k       = hdr_field(s.s_data, HDR_K_LSB);
  assign hdr_n       = hdr_field(s.s_data, HDR_N_LSB);
  assign hdr_a_total = {8'd0, hdr_m} * {8'd0, hdr_k};
  assign hdr_b_total = {8'd0, hdr_k} * {8'd0, hdr_n};

`ifdef LOADER_HDR_CHECK_EN
  assign hdr_ok = (hdr_m != 8'd0) && (hdr_k != 8'd0) && (hdr_n != 8'd0) &&
                  (int'(hdr_m) <= MAX_M) && (int'(hdr_k) <= MAX_K) && (int'(hdr_n) <= MAX_N);
`else
  assign hdr_ok = 1'b1;
`endif

  logic accept;
  logic last_a, last_b;
  logic wr_a, wr_b;

  assign accept = s.s_valid && s.s_ready;
  assign last_a = (cnt_q == a_total_q - 16'd1);
  assign last_b = (cnt_q == b_total_q - 16'd1);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    s.s_ready = 1'b0;
    eng_start = 1'b0;
    busy      = (state_q != IDLE);
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    case (state_q)
      IDLE: begin
        s.s_ready = 1'b1;
        if (s.s_valid && hdr_ok) begin
          // Empty phases are skipped; K=0 empties both and goes straight to START.
          if (hdr_a_total != '0)      state_d = LOAD_A;
          else if (hdr_b_total != '0) state_d = LOAD_B;
          else                        state_d = START;
        end
      end
      LOAD_A: begin
        s.s_ready = 1'b1;
        if (s.s_valid) begin
          wr_a = 1'b1;
          if (last_a) state_d = (b_total_q != '0) ? LOAD_B : START;
        end
      end
      LOAD_B: begin
        s.s_ready = 1'b1;
        if (s.s_valid) begin
          wr_b = 1'b1;
          if (last_b) state_d = START;
        end
      end
      START: begin
        eng_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (eng_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Dimensions, totals, element counter, sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      a_total_q <= '0;
      b_total_q <= '0;
      M_val     <= '0;
      K_val     <= '0;
      N_val     <= '0;
`ifdef LOADER_HDR_CHECK_EN
      err       <= 1'b0;
`endif
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (hdr_ok) begin
            M_val     <= hdr_m;
            K_val     <= hdr_k;
            N_val     <= hdr_n;
            a_total_q <= hdr_a_total;
            b_total_q <= hdr_b_total;
            cnt_q     <= '0;
`ifdef LOADER_HDR_CHECK_EN
            err       <= 1'b0;
`endif
          end else begin
`ifdef LOADER_HDR_CHECK_EN
            err       <= 1'b1;
`endif
          end
        end
        LOAD_A:  cnt_q <= last_a ? '0 : cnt_q + 16'd1;
        LOAD_B:  cnt_q <= last_b ? '0 : cnt_q + 16'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand arrays: not reset, so entries outside the current load (and
  // partial data after an aborted load) keep their previous contents.
  // Out-of-range indices from oversized headers are dropped here.
  // ---------------------------------------------------------------------------
  logic [A_AW-1:0] a_idx;
  logic [B_AW-1:0] b_idx;
  logic            a_in_range, b_in_range;

  assign a_idx      = A_AW'(cnt_q);
  assign b_idx      = B_AW'(cnt_q);
  assign a_in_range = (int'(cnt_q) < A_DEPTH);
  assign b_in_range = (int'(cnt_q) < B_DEPTH);

  always_ff @(posedge clk) begin
    if (wr_a && a_in_range) matrix_A[a_idx] <= s.s_data;
    if (wr_b && b_in_range) matrix_B[b_idx] <= s.s_data;
  end

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

- Streaming front-end placed directly upstream of the matrix-multiply engine.
- Accepts one 32-bit word stream carrying a dimension header, then matrix A, then matrix B, all row-major.
- Writes the words into on-block operand arrays that connect straight to the engine's `matrix_A`/`matrix_B` inputs.
- Pulses the engine's `start`, then holds off new input until the engine reports `done`.

## Interface

Parameters:

- `MAX_M`, default 100: maximum rows of A; must match the engine.
- `MAX_K`, default 100: maximum inner dimension; must match the engine.
- `MAX_N`, default 100: maximum columns of B; must match the engine.

Ports:

- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `s_valid`, in, 1: input word valid.
- `s_ready`, out, 1: loader can accept a word.
- `s_data`, in, 32: input word.
- `M_val`, `K_val`, `N_val`, out, 8 each: latched dimensions, to the engine.
- `matrix_A`, out, 32 × (MAX_M·MAX_K): operand A array.
- `matrix_B`, out, 32 × (MAX_K·MAX_N): operand B array.
- `eng_start`, out, 1: one-cycle start pulse to the engine.
- `eng_done`, in, 1: engine completion.
- `busy`, out, 1: high in every state except IDLE.
- `err`, out, 1: sticky header error; exists only with `LOADER_HDR_CHECK_EN`.

## Operation

Header word layout:

- `[7:0]` = M, `[15:8]` = K, `[23:16]` = N.
- `[31:24]` is ignored.

States:

- IDLE
  - `s_ready`=1.
  - An accepted word is the header: latch M/K/N, compute `a_total`=M·K and `b_total`=K·N (16-bit unsigned products), clear the element counter, go to LOAD_A.
- LOAD_A
  - `s_ready`=1.
  - Each accepted word is written to `matrix_A[cnt]`, then `cnt` increments.
  - On the beat where `cnt`=`a_total`−1: clear `cnt`, go to LOAD_B.
- LOAD_B
  - Same as LOAD_A, writing `matrix_B[cnt]` against `b_total`.
  - On the last beat, go to START.
- START
  - `s_ready`=0; `eng_start`=1 for exactly this one cycle.
  - Go to WAIT.
- WAIT
  - `s_ready`=0.
  - `eng_done` is sampled only in this state; when it is high, go to IDLE.

Rules:

- A transfer occurs only when `s_valid` && `s_ready`. `s_valid` low stalls the load indefinitely with no state change.
- If a phase total is 0 (possible only without the check), that phase is skipped: IDLE→LOAD_B, or LOAD_A→START.
- `M_val`/`K_val`/`N_val` hold their values until the next accepted header. They stay stable through START and WAIT.
- Array entries not written in the current load keep their previous contents.
- `eng_done` outside WAIT is ignored.

## Timing

- `s_ready` is a combinational decode of the state register only. It never depends on `s_valid`.
- Array writes and counter updates take effect at the edge of the accepting cycle.
- The last B beat at edge t gives `eng_start` high during cycle t+1. `busy` stays high through that cycle.
- `eng_done` sampled high at edge u gives IDLE, with `s_ready`=1, in cycle u+1.
- Full load latency is 1 + a_total + b_total accepted beats, plus 1 START cycle.
- Reset values:
  - State IDLE, `cnt`=0.
  - `M_val`=`K_val`=`N_val`=0.
  - `eng_start`=0, `busy`=0, `err`=0.
  - Arrays are not reset.
- Reset asserted mid-load or in WAIT aborts immediately. Partial array contents remain. After release, the first accepted word is a header.

## Configuration

Macro: `LOADER_HDR_CHECK_EN`.

- Defined:
  - A header with M, K or N equal to 0, or with M>MAX_M, K>MAX_K or N>MAX_N, is consumed and dropped.
  - The state stays IDLE, dimensions are unchanged, and `err` is set in the next cycle.
  - `err` clears on the next accepted valid header, or on reset.
- Undefined:
  - There is no `err` port and no checks.
  - Any header is accepted, and the zero-total skip rule applies.
  - Exceeding the maximums is the producer's responsibility; writes beyond array bounds are discarded.

## Structure

- Shared package `matmul_pkg`:
  - State encoding (IDLE/LOAD_A/LOAD_B/START/WAIT).
  - Header field offsets.
  - 16-bit index width constant, shared with the engine's index math.
- No sub-module: one FSM, one element counter, two write-decoded arrays.

## Test plan

- **Basic load:** header 0x00_02_03_02 (M=2, K=3, N=2), A=1..6, B=7..12.
  - `matrix_A[0..5]`=1..6 and `matrix_B[0..5]`=7..12.
  - `eng_start` pulses one cycle after the 13th beat.
  - `s_ready` stays 0 until `eng_done`.
- **Back-pressure and bubbles:** random `s_valid` gaps during the 2×3×2 load give identical array contents. `eng_done` asserted 5 cycles after `eng_start` gives `s_ready`=1 on the following cycle.
- **Header check:** with `LOADER_HDR_CHECK_EN`, header K=0 or M=101 gives `err`=1, state IDLE, `M_val` unchanged. A following valid header clears `err`.
- **Reset mid-load:** `rst` after 2 A beats gives all outputs at their reset values and `s_ready`=1. The next word is treated as a header.
- **Edge dimensions:**
  - 1×1×1: exactly 3 beats, then `eng_start`.
  - 100×100×100: 20001 beats; the last writes land at index 9999 of each array.
- **Spurious done:** `eng_done` pulsed during LOAD_A is ignored and the load continues normally.
